// File: rtl/isa_target_pkg.sv
// -----------------------------------------------------------------------------
// isa_target_pkg
// Shared types and constants for the ISA I/O target responder.
//   state_t       : handshake FSM states (IDLE, WAIT, ACTIVE)
//   REG_IRQ_STAT  : offset of the interrupt status register (read clears irq)
//   REG_IRQ_TRIG  : offset of the interrupt trigger register (bit0 sets irq)
//   REG_DEPTH     : number of byte registers in the I/O window
// -----------------------------------------------------------------------------
package isa_target_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACTIVE
  } state_t;

  localparam logic [3:0] REG_IRQ_STAT = 4'hE;
  localparam logic [3:0] REG_IRQ_TRIG = 4'hF;
  localparam int         REG_DEPTH    = 16;

endpackage

// File: rtl/isa_sync.sv
// -----------------------------------------------------------------------------
// isa_sync
// Multi-flop synchroniser for one active-low asynchronous ISA strobe.
// The chain resets to 1 so an idle (deasserted) strobe is the reset level.
// Ports:
//   clk       : sampling clock
//   reset     : synchronous, active-high
//   async_in  : raw asynchronous strobe
//   sync_out  : strobe level after SYNC_STAGES flops
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module isa_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/isa_io_target.sv
// -----------------------------------------------------------------------------
// isa_io_target
// Device-side responder for 8-bit ISA I/O cycles. Decodes a 16-byte window at
// BASE_ADDR, stretches each hit with WAIT_CYCLES IOCHRDY wait states, serves
// reads from / commits writes to a 16 x 8 register file, and exposes a
// software-triggered interrupt (write bit0=1 to 0xF, read 0xE to clear).
// Ports:
//   clk_50MHz : sole clock
//   reset     : synchronous, active-high (ISA RESET)
//   A         : ISA address
//   AEN       : high during DMA cycles, suppresses decode
//   IOR_n     : asynchronous I/O read strobe, active-low
//   IOW_n     : asynchronous I/O write strobe, active-low
//   data_in   : D[7:0] as seen by the target
//   data_out  : read data
//   data_oe   : high while the target drives D[7:0]
//   IOCHRDY   : low inserts wait states
//   irq       : interrupt request, active-high
// -----------------------------------------------------------------------------
module isa_io_target #(
  parameter logic [15:0] BASE_ADDR   = 16'h0220,
  parameter int          WAIT_CYCLES = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic        AEN,
  input  logic        IOR_n,
  input  logic        IOW_n,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        IOCHRDY,
  output logic        irq
);

  import isa_target_pkg::*;

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam int SW = $clog2(SYNC_STAGES + 1);

  logic          rd_sync;
  logic          wr_sync;
  logic [SW-1:0] settle_cnt;
  logic          settled;
  logic          rd_hist;
  logic          wr_hist;
  logic          rd_fall;
  logic          wr_fall;
  logic          both_asserted;
  logic          hit;
  logic          strobe_released;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          cyc_read;
  logic [3:0]    cyc_off;
  logic          commit_pend;
  logic [7:0]    regs [REG_DEPTH];

  isa_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
    .clk      (clk_50MHz),
    .reset    (reset),
    .async_in (IOR_n),
    .sync_out (rd_sync)
  );

  isa_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .clk      (clk_50MHz),
    .reset    (reset),
    .async_in (IOW_n),
    .sync_out (wr_sync)
  );

  // The synchroniser outputs its reset value (deasserted) until it has
  // shifted in SYNC_STAGES real samples. The edge history is frozen at
  // "asserted" until then, so a strobe held low through reset must first be
  // seen high before it can produce a falling edge.
  assign settled = (settle_cnt == SW'(SYNC_STAGES));

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      settle_cnt <= '0;
      rd_hist    <= 1'b0;
      wr_hist    <= 1'b0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + 1'b1;
    end else begin
      rd_hist <= rd_sync;
      wr_hist <= wr_sync;
    end
  end

  assign rd_fall       = settled & rd_hist & ~rd_sync;
  assign wr_fall       = settled & wr_hist & ~wr_sync;
  assign both_asserted = ~rd_sync & ~wr_sync;

  // A and AEN are sampled combinationally on the edge-detect cycle.
  assign hit = (rd_fall | wr_fall) & ~both_asserted & ~AEN &
               (A[15:4] == BASE_ADDR[15:4]);

  assign strobe_released = cyc_read ? rd_sync : wr_sync;

  // Handshake FSM with registered outputs. The commit (register write or
  // IRQ_STAT read-clear) is performed at the end of the first ACTIVE cycle,
  // so its effect on irq is visible one clock after that cycle.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cyc_read    <= 1'b0;
      cyc_off     <= '0;
      commit_pend <= 1'b0;
      data_out    <= '0;
      data_oe     <= 1'b0;
      IOCHRDY     <= 1'b1;
      irq         <= 1'b0;
      for (int i = 0; i < REG_DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            cyc_read <= rd_fall;
            cyc_off  <= A[3:0];
            if (rd_fall) begin
              data_oe  <= 1'b1;
              data_out <= (A[3:0] == REG_IRQ_STAT) ? {7'b0, irq} : regs[A[3:0]];
            end
            if (WAIT_CYCLES == 0) begin
              state       <= ACTIVE;
              commit_pend <= 1'b1;
            end else begin
              state   <= WAIT;
              IOCHRDY <= 1'b0;
              cnt     <= CNT_INIT;
            end
          end
        end

        WAIT: begin
          // A host abort wins over an expiring counter: nothing is committed.
          if (strobe_released) begin
            state   <= IDLE;
            IOCHRDY <= 1'b1;
            data_oe <= 1'b0;
          end else if (cnt == '0) begin
            state       <= ACTIVE;
            IOCHRDY     <= 1'b1;
            commit_pend <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ACTIVE: begin
          if (commit_pend) begin
            commit_pend <= 1'b0;
            if (cyc_read) begin
              if (cyc_off == REG_IRQ_STAT) begin
                irq <= 1'b0;
              end
            end else if (cyc_off == REG_IRQ_TRIG) begin
              regs[cyc_off] <= data_in;
              if (data_in[0]) begin
                irq <= 1'b1;
              end
            end else if (cyc_off != REG_IRQ_STAT) begin
              regs[cyc_off] <= data_in;
            end
          end
          if (strobe_released) begin
            state   <= IDLE;
            data_oe <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_isa_io_target.sv
// -----------------------------------------------------------------------------
// tb_isa_io_target
// Self-checking bench for isa_io_target. Stimulus drives ISA read/write
// cycles and pushes the expected response into a scoreboard queue, computed
// from a simple array model of the register file and irq flag. An independent
// monitor watches IOCHRDY and pops/compares one entry per response.
// -----------------------------------------------------------------------------
module tb_isa_io_target;

  localparam logic [15:0] BASE  = 16'h0220;
  localparam int          WAITC = 4;
  localparam int          SYNC  = 2;

  logic        clk_50MHz = 1'b0;
  logic        reset     = 1'b1;
  logic [15:0] A         = '0;
  logic        AEN       = 1'b0;
  logic        IOR_n     = 1'b1;
  logic        IOW_n     = 1'b1;
  logic [7:0]  data_in   = '0;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        IOCHRDY;
  logic        irq;

  isa_io_target #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAITC),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .A         (A),
    .AEN       (AEN),
    .IOR_n     (IOR_n),
    .IOW_n     (IOW_n),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .IOCHRDY   (IOCHRDY),
    .irq       (irq)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int total  = 0;
  int bad    = 0;
  int pe_cnt = 0;
  int rise_pe = 0;

  always @(posedge clk_50MHz) pe_cnt <= pe_cnt + 1;

  typedef struct {
    bit         is_read;
    bit         aborted;
    logic [7:0] data;
    bit         irq;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_regs [16];
  bit         m_irq;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic waitChrdy(input logic level, input string name);
    int n;
    n = 0;
    @(negedge clk_50MHz);
    while (IOCHRDY !== level && n < 100) begin
      @(negedge clk_50MHz);
      n++;
    end
    if (n >= 100) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_irq = 1'b0;
  endtask

  // Behavioural model of one committed access.
  task automatic modelAccess(input bit is_read, input logic [3:0] off,
                             input logic [7:0] wdata, output exp_t e);
    e.is_read = is_read;
    e.aborted = 1'b0;
    e.data    = '0;
    if (is_read) begin
      if (off == 4'hE) begin
        e.data = {7'b0, m_irq};
        m_irq  = 1'b0;
      end else begin
        e.data = m_regs[off];
      end
    end else if (off != 4'hE) begin
      m_regs[off] = wdata;
      if (off == 4'hF && wdata[0]) m_irq = 1'b1;
    end
    e.irq = m_irq;
  endtask

  // mode 0 = complete cycle, mode 1 = release strobe during the wait states.
  task automatic applyStimulus(input bit is_read, input logic [15:0] addr,
                               input bit aen, input logic [7:0] wdata, input int mode);
    exp_t e;
    bit   is_hit;
    bit   quiet;
    A       = addr;
    AEN     = aen;
    data_in = wdata;
    is_hit  = !aen && (addr[15:4] == BASE[15:4]);
    if (is_hit) begin
      if (mode == 1) begin
        e.is_read = is_read;
        e.aborted = 1'b1;
        e.data    = '0;
        e.irq     = m_irq;
      end else begin
        modelAccess(is_read, addr[3:0], wdata, e);
      end
      sb.push_back(e);
    end
    tick();
    if (is_read) IOR_n = 1'b0; else IOW_n = 1'b0;
    if (is_hit && mode == 1) begin
      waitChrdy(1'b0, "abort_start");
      IOR_n = 1'b1;
      IOW_n = 1'b1;
    end else if (is_hit) begin
      waitChrdy(1'b0, "resp_start");
      waitChrdy(1'b1, "resp_end");
      tick();
      tick();
      rise_pe = pe_cnt;
      IOR_n = 1'b1;
      IOW_n = 1'b1;
    end else begin
      quiet = 1'b1;
      repeat (12) begin
        @(negedge clk_50MHz);
        if (IOCHRDY !== 1'b1 || data_oe !== 1'b0) quiet = 1'b0;
      end
      checkOutput("miss_quiet", quiet, 1);
      IOR_n = 1'b1;
      IOW_n = 1'b1;
    end
    repeat (8) tick();
    AEN = 1'b0;
  endtask

  // Monitor: one scoreboard entry per IOCHRDY low pulse.
  initial begin : monitor
    exp_t       e;
    int         lowc;
    int         n;
    bit         held;
    logic       oe_s;
    logic [7:0] dout_s;
    logic       irq_s;
    forever begin
      @(negedge clk_50MHz);
      if (IOCHRDY === 1'b0) begin
        lowc = 1;
        while (lowc < 200) begin
          @(negedge clk_50MHz);
          if (IOCHRDY === 1'b0) lowc++;
          else break;
        end
        oe_s   = data_oe;
        dout_s = data_out;
        @(negedge clk_50MHz);
        irq_s = irq;
        if (sb.size() == 0) begin
          checkOutput("unexpected_response", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.aborted) begin
            checkOutput("abort_wait_short", (lowc < WAITC), 1);
            checkOutput("abort_oe", oe_s, 0);
          end else begin
            checkOutput("wait_len", lowc, WAITC);
            checkOutput("oe_at_commit", oe_s, e.is_read);
            if (e.is_read) begin
              checkOutput("read_data", dout_s, e.data);
              held = 1'b1;
              n    = 0;
              while (data_oe === 1'b1 && n < 100) begin
                if (data_out !== e.data) held = 1'b0;
                @(negedge clk_50MHz);
                n++;
              end
              checkOutput("data_hold", held, 1);
              checkOutput("oe_drop_clks", pe_cnt - rise_pe, SYNC + 1);
            end
          end
          checkOutput("irq_after", irq_s, e.irq);
        end
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    bit   quiet;
    int   r;
    logic [3:0]  off;
    logic [15:0] addr;
    modelReset();

    repeat (3) @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    checkOutput("rst_data_out", data_out, 8'h00);
    checkOutput("rst_data_oe", data_oe, 0);
    checkOutput("rst_iochrdy", IOCHRDY, 1);
    checkOutput("rst_irq", irq, 0);
    tick();
    reset = 1'b0;
    repeat (5) tick();

    // write / read-back
    applyStimulus(0, 16'h0223, 0, 8'h5A, 0);
    applyStimulus(1, 16'h0223, 0, 8'h00, 0);

    // misses: outside the window, and DMA cycle inside it
    applyStimulus(1, 16'h0230, 0, 8'h00, 0);
    applyStimulus(0, 16'h0223, 1, 8'hFF, 0);
    applyStimulus(1, 16'h0223, 0, 8'h00, 0);

    // interrupt set, read-clear, second read, trigger readback
    applyStimulus(0, 16'h022F, 0, 8'h01, 0);
    applyStimulus(1, 16'h022E, 0, 8'h00, 0);
    applyStimulus(1, 16'h022E, 0, 8'h00, 0);
    applyStimulus(1, 16'h022F, 0, 8'h00, 0);

    // conflicting strobes are ignored
    A     = 16'h0220;
    IOR_n = 1'b0;
    IOW_n = 1'b0;
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk_50MHz);
      if (IOCHRDY !== 1'b1 || data_oe !== 1'b0) quiet = 1'b0;
    end
    checkOutput("conflict_quiet", quiet, 1);
    tick();
    IOR_n = 1'b1;
    IOW_n = 1'b1;
    repeat (8) tick();
    applyStimulus(1, 16'h0220, 0, 8'h00, 0);

    // host abort during the wait states
    applyStimulus(0, 16'h0221, 0, 8'h77, 1);
    applyStimulus(1, 16'h0221, 0, 8'h00, 0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      r    = $urandom_range(0, 9);
      off  = 4'($urandom_range(0, 15));
      addr = {BASE[15:4], off};
      if (r == 7) addr = 16'($urandom);
      applyStimulus(bit'($urandom_range(0, 1)), addr, (r == 8),
                    8'($urandom), (r == 9) ? 1 : 0);
    end

    // make sure some state is set before the mid-cycle reset
    applyStimulus(0, 16'h0225, 0, 8'hC3, 0);
    applyStimulus(0, 16'h022F, 0, 8'h01, 0);

    // reset during WAIT with IOR_n held low
    A = 16'h0225;
    e.is_read = 1'b1;
    e.aborted = 1'b1;
    e.data    = '0;
    e.irq     = 1'b0;
    sb.push_back(e);
    tick();
    IOR_n = 1'b0;
    waitChrdy(1'b0, "rst_mid_start");
    reset = 1'b1;
    modelReset();
    tick();
    reset = 1'b0;
    @(negedge clk_50MHz);
    checkOutput("midrst_data_out", data_out, 8'h00);
    checkOutput("midrst_data_oe", data_oe, 0);
    checkOutput("midrst_iochrdy", IOCHRDY, 1);
    checkOutput("midrst_irq", irq, 0);
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk_50MHz);
      if (IOCHRDY !== 1'b1 || data_oe !== 1'b0) quiet = 1'b0;
    end
    checkOutput("midrst_held_quiet", quiet, 1);
    tick();
    IOR_n = 1'b1;
    repeat (8) tick();
    applyStimulus(1, 16'h0225, 0, 8'h00, 0);
    applyStimulus(0, 16'h0225, 0, 8'h3C, 0);
    applyStimulus(1, 16'h0225, 0, 8'h00, 0);
    applyStimulus(1, 16'h022E, 0, 8'h00, 0);

    repeat (10) tick();
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/isa_io_target.md
# isa_io_target

Device-side responder for the 8-bit ISA I/O cycles the riser's host bridge generates on IOR/IOW/A/D/AEN. It decodes a 16-byte I/O window at a fixed base and synchronises the asynchronous strobes into clk_50MHz. It stretches each hit with IOCHRDY wait states, then serves reads from, and commits writes to, a local register file. It also raises a software-triggerable interrupt, so the host bridge can be exercised end-to-end without a real card.

## Interface
- BASE_ADDR, 16'h0220, I/O window base; low 4 bits ignored.
- WAIT_CYCLES, 4, clocks IOCHRDY is held low per hit; 0 = no wait states.
- SYNC_STAGES, 2, synchroniser depth on IOR_n/IOW_n; minimum 2.
- clk_50MHz  in  1  sole clock.
- reset  in  1  synchronous, active-high; ISA RESET.
- A  in  16  ISA address.
- AEN  in  1  high = DMA cycle; no decode.
- IOR_n  in  1  I/O read strobe, active-low, asynchronous.
- IOW_n  in  1  I/O write strobe, active-low, asynchronous.
- data_in  in  8  D[7:0] as seen by the target.
- data_out  out  8  read data.
- data_oe  out  1  high = target drives D[7:0].
- IOCHRDY  out  1  low = insert wait states.
- irq  out  1  interrupt request, active-high.

## Operation
- Register file: 16 × 8 bits, offset = A[3:0].
  - 0x0–0xD: scratch, read/write.
  - 0xE IRQ_STAT: reads {7'b0, irq}; the read clears irq; writes are ignored.
  - 0xF IRQ_TRIG: write with bit0 = 1 sets irq; reads return the last written value.
- Hit: synchronised strobe transitions to asserted, AEN = 0, and A[15:4] == BASE_ADDR[15:4]. A and AEN are sampled on the edge-detect cycle.
- States:
  - IDLE → WAIT on a hit (→ ACTIVE directly if WAIT_CYCLES = 0).
  - WAIT → ACTIVE when the counter expires.
  - WAIT → IDLE if the strobe deasserts first (host abort).
  - ACTIVE → IDLE when the synchronised strobe deasserts.
  - A strobe edge that is not a hit leaves the FSM in IDLE; that cycle is ignored.
- Commit, on the single cycle entering ACTIVE:
  - Write: reg[A[3:0]] ← data_in.
  - Read of 0xE: irq ← 0.
- Host abort during WAIT: no commit, no irq change.
- IOR_n and IOW_n both synchronised-asserted: ignored, no decode. The FSM stays in IDLE until both deassert.
- irq set and clear on the same commit cannot occur: each commit is a single access.

## Timing
- Reset values:
  - data_out = 0x00, data_oe = 0, IOCHRDY = 1, irq = 0.
  - All registers = 0x00; FSM = IDLE.
  - Edge-detector history = "asserted", so a strobe held through reset never creates a hit. It must deassert and reassert first.
- Reset mid-cycle: all reset values apply on the next edge; any in-flight commit is dropped.
- Strobe latency: SYNC_STAGES clocks to synchronised level, plus 1 clock for edge detect.
- Edge-detect cycle E (hit) → at E+1: IOCHRDY = 0; for reads, data_oe = 1 and data_out = reg[A[3:0]] (IRQ_STAT returns the pre-clear value).
- IOCHRDY stays low for exactly WAIT_CYCLES clocks. It returns to 1 on the cycle the FSM enters ACTIVE, which is also the commit cycle.
- irq changes one cycle after commit.
- data_oe drops on the cycle the FSM returns to IDLE, i.e. SYNC_STAGES+1 clocks after IOR_n rises.
- data_out holds its value through ACTIVE.
- Write data must be stable from IOW_n fall through the commit cycle; ISA write timing guarantees this.

## Structure
- Package isa_target_pkg:
  - state enum {IDLE, WAIT, ACTIVE};
  - offsets REG_IRQ_STAT = 4'hE and REG_IRQ_TRIG = 4'hF;
  - register-file depth constant 16.
- Sub-module isa_sync: parameterised SYNC_STAGES flop chain with reset value 1 (deasserted-low strobe idle). Instantiated once per strobe.
- Wait counter width: $clog2(WAIT_CYCLES+1), minimum 1.

## Test plan
- Write/read-back: IOW 0x5A to 0x0223, then IOR 0x0223 → IOCHRDY low 4 clocks per cycle; data_out = 0x5A with data_oe high until IOR_n rise + 3 clocks.
- Miss: IOR to 0x0230, and IOW to 0x0223 with AEN = 1 → data_oe stays 0, IOCHRDY stays 1, reg[3] unchanged.
- Interrupt: IOW 0x01 to 0x022F → irq = 1 one clock after commit.
  - IOR 0x022E → returns 0x01; irq = 0 after.
  - Second IOR 0x022E → returns 0x00.
- Conflict: IOR_n and IOW_n low together → no response. After both release, IOR 0x0220 → normal response.
- Abort: IOW 0x77 to 0x0221 with IOW_n released after 1 clock of WAIT → FSM to IDLE, IOCHRDY 1, reg[1] unchanged.
- Reset mid-cycle: reset during WAIT with IOR_n held low → next clock all outputs at reset values. No response until IOR_n rises and falls again; that access then behaves normally.
